// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble, one bit per cycle)
// with leading-zero blank flags for a seven-segment display chain.
module bin_to_bcd_seq (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [15:0] i_bin,
  output logic [19:0] o_bcd,
  output logic [4:0]  o_blank,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned BIN_W = 16;
  localparam int unsigned DIG_N = 5;
  localparam int unsigned BCD_W = 20;
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Counter value seen on the final (16th) conversion edge
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(15);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_scr;
  logic [CNT_W-1:0] r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic [DIG_N-1:0] r_blank;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_scr_nxt;
  logic [BIN_W-1:0] w_shift_nxt;
  logic [DIG_N-1:0] w_zero;
  logic [DIG_N-1:0] w_blank_nxt;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; START is ignored while converting
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CONV;
      S_CONV:  if (r_cnt == LAST_STEP) w_next = S_FIN;
      S_FIN:   w_next = i_start ? S_CONV : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM decodes: accept/last-step strobes and next values of the BUSY/DONE registers
  always_comb begin
    w_accept   = i_start && ((r_state == S_IDLE) || (r_state == S_FIN));
    w_last     = (r_state == S_CONV) && (r_cnt == LAST_STEP);
    w_busy_nxt = (w_next == S_CONV);
    w_done_nxt = (w_next == S_FIN);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {scratch,shift} left
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < int'(DIG_N); i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
    end
    {w_scr_nxt, w_shift_nxt} = {w_adj[BCD_W-2:0], r_shift, 1'b0};
  end

  // Leading-zero blanking of the finished result; units digit always lit
  always_comb begin
    for (int i = 0; i < int'(DIG_N); i++) begin
      w_zero[i] = (w_scr_nxt[4*i +: 4] == 4'd0);
    end
    w_blank_nxt[4] = w_zero[4];
    w_blank_nxt[3] = w_zero[4] & w_zero[3];
    w_blank_nxt[2] = w_zero[4] & w_zero[3] & w_zero[2];
    w_blank_nxt[1] = w_zero[4] & w_zero[3] & w_zero[2] & w_zero[1];
    w_blank_nxt[0] = 1'b0;
  end

  // Conversion datapath; the visible result only changes on the last step
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_shift <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_blank <= 5'b11110;
    end else if (w_accept) begin
      r_shift <= i_bin;
      r_scr   <= '0;
      r_cnt   <= '0;
    end else if (r_state == S_CONV) begin
      r_shift <= w_shift_nxt;
      r_scr   <= w_scr_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_bcd   <= w_scr_nxt;
        r_blank <= w_blank_nxt;
      end
    end
  end

  // Registered status outputs: BUSY mirrors CONV, DONE mirrors FIN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign o_bcd   = r_bcd;
  assign o_blank = r_blank;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: driver pushes expected results, a negedge
// monitor pops and compares on every DONE pulse and checks result hold otherwise.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        i_reset_n;
  logic        i_start;
  logic [15:0] i_bin;
  logic [19:0] o_bcd;
  logic [4:0]  o_blank;
  logic        o_busy;
  logic        o_done;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        it;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  logic [19:0] last_bcd = 20'h0;
  logic [4:0]  last_blank = 5'b11110;

  bin_to_bcd_seq dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_start   (i_start),
    .i_bin     (i_bin),
    .o_bcd     (o_bcd),
    .o_blank   (o_blank),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, blank[i] iff value < 10^i (i >= 1)
  function automatic logic [24:0] model(input int v);
    logic [19:0] b;
    logic [4:0]  z;
    int          p;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'((v / p) % 10);
      z[i]        = (i > 0) && (v < p);
      p           = p * 10;
    end
    return {b, z};
  endfunction

  // Monitor: compare on DONE, otherwise the displayed result must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got bcd=%0h with no conversion pending", o_bcd);
        end else begin
          int dec;
          bit dig_ok;
          int p;
          it = q.pop_front();
          chk("done_cycle", cyc, it.cyc);
          chk("bcd", o_bcd, it.bcd);
          chk("blank", o_blank, it.blank);
          dec = 0;
          p = 1;
          dig_ok = 1'b1;
          for (int i = 0; i < 5; i++) begin
            if (o_bcd[4*i +: 4] > 4'd9) dig_ok = 1'b0;
            dec = dec + int'(o_bcd[4*i +: 4]) * p;
            p = p * 10;
          end
          chk("digits_le_9", dig_ok, 1);
          chk("decimal_value", dec, int'(it.bin));
          last_bcd   = it.bcd;
          last_blank = it.blank;
        end
      end else begin
        chk("hold_bcd", o_bcd, last_bcd);
        chk("hold_blank", o_blank, last_blank);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one conversion from posedge+1; returns at posedge+1 in the FIN cycle
  task automatic conv(input logic [15:0] v, input bit hold, input logic [15:0] hb,
                      input bit chk_c, input logic [19:0] eb, input logic [4:0] el);
    exp_t e;
    logic [24:0] m;
    m = model(int'(v));
    e.bin = v;
    e.bcd = m[24:5];
    e.blank = m[4:0];
    e.cyc = cyc + 17;
    q.push_back(e);
    i_start = 1'b1;
    i_bin = v;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      i_start = hold;
      i_bin = hold ? hb : 16'($urandom);
      chk("busy_in_conv", o_busy, 1);
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("busy_in_fin", o_busy, 0);
    chk("done_in_fin", o_done, 1);
    if (chk_c) begin
      chk("bcd_const", o_bcd, eb);
      chk("blank_const", o_blank, el);
    end
  endtask

  // Start a conversion and pull reset (with START high) on the 8th CONV edge
  task automatic conv_abort(input logic [15:0] v);
    i_start = 1'b1;
    i_bin = v;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
      if (k == 7) begin
        i_reset_n = 1'b0;
        i_start = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    last_bcd = 20'h0;
    last_blank = 5'b11110;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_bcd", o_bcd, 20'h0);
    chk("abort_blank", o_blank, 5'b11110);
    i_reset_n = 1'b1;
    i_start = 1'b0;
    idle(20);
    chk("abort_idle_busy", o_busy, 0);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_start = 1'b1;
    i_bin = 16'd1234;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd", o_bcd, 20'h0);
    chk("rst_blank", o_blank, 5'b11110);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    i_start = 1'b0;
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    conv(16'd0, 0, 16'd0, 1, 20'h00000, 5'b11110);
    idle(2);
    conv(16'hFFFF, 0, 16'd0, 1, 20'h65535, 5'b00000);
    idle(1);
    conv(16'd1234, 0, 16'd0, 1, 20'h01234, 5'b10000);
    idle(3);
    conv(16'd9999, 0, 16'd0, 1, 20'h09999, 5'b10000);
    idle(1);
    conv(16'd10000, 0, 16'd0, 1, 20'h10000, 5'b00000);
    idle(2);

    conv(16'd42, 1, 16'd7, 1, 20'h00042, 5'b11100);
    conv(16'd7, 0, 16'd0, 1, 20'h00007, 5'b11110);
    idle(2);

    conv_abort(16'd54321);
    conv(16'd805, 0, 16'd0, 1, 20'h00805, 5'b11000);
    idle(1);

    for (int n = 0; n < 1000; n++) begin
      conv(16'($urandom), ($urandom_range(3) == 0), 16'($urandom), 0, 20'h0, 5'h0);
      if ($urandom_range(1) == 1) idle(int'($urandom_range(3, 1)));
    end

    idle(5);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
